// File: rtl/div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Pure definitions, no logic, no latency.
// No handshake of its own; the divider uses these for state and ALU control.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_COMPUTE = 2'd2,
    S_RES     = 2'd3
  } div_state_t;

  // Partial-remainder ALU operation: clear on operand load, trial-subtract while computing.
  localparam logic ALU_CLR = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Ceiling log2, used to size the bit counter so it can hold WIDTH itself.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_fsm.sv
// Divider controller: IDLE -> INIT -> COMPUTE x WIDTH -> RES -> IDLE (INIT -> RES on zero divisor).
// Outputs are combinational decodes of the registered state, zero added latency.
// GO is only looked at in IDLE; requests arriving while busy are dropped, not queued.
module div_fsm
  import div_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic go_i,
  input  logic b_is_zero_i,
  input  logic cnt_eq_1_i,
  output logic capture_o,
  output logic load_o,
  output logic shift_o,
  output logic res_load_o,
  output logic alu_op_o,
  output logic ready_o,
  output logic init_o,
  output logic compute_o,
  output logic res_o
);

  div_state_t state_q, state_d;

  // State register; reset parks the controller in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (go_i) state_d = S_INIT;
      S_INIT:    state_d = b_is_zero_i ? S_RES : S_COMPUTE;
      S_COMPUTE: if (cnt_eq_1_i) state_d = S_RES;
      S_RES:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; strobes stay one-hot and an illegal state reads as IDLE.
  always_comb begin
    capture_o  = 1'b0;
    load_o     = 1'b0;
    shift_o    = 1'b0;
    res_load_o = 1'b0;
    alu_op_o   = ALU_SUB;
    ready_o    = 1'b0;
    init_o     = 1'b0;
    compute_o  = 1'b0;
    res_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o   = 1'b1;
        capture_o = go_i;
      end
      S_INIT: begin
        init_o   = 1'b1;
        load_o   = 1'b1;
        alu_op_o = ALU_CLR;
      end
      S_COMPUTE: begin
        compute_o = 1'b1;
        shift_o   = 1'b1;
      end
      S_RES: begin
        res_o      = 1'b1;
        res_load_o = 1'b1;
      end
      default: ready_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Result/VALID land WIDTH+2 edges after GO is accepted (2 edges when B==0); WIDTH+3 cycles per op.
// GO/READY start handshake only; GO outside IDLE is ignored, results hold until the next load.
module seq_unsigned_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             SYS_CLOCK,
  input  logic             FSM_ARESET_N,
  input  logic             GO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             VALID,
  output logic             DIV_BY_ZERO,
  output logic             READY,
  output logic             INIT,
  output logic             COMPUTE,
  output logic             RES
);

  localparam int CW = clog2(WIDTH + 1);

  logic capture, load, shift, res_load, alu_op;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dq_q, dq_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             valid_q, valid_d, dbz_q, dbz_d;

  logic [WIDTH:0]   pr_sh, trial;
  logic             borrow;

  div_fsm u_fsm (
    .clk_i       (SYS_CLOCK),
    .rst_ni      (FSM_ARESET_N),
    .go_i        (GO),
    .b_is_zero_i (b_q == '0),
    .cnt_eq_1_i  (cnt_q == CW'(1)),
    .capture_o   (capture),
    .load_o      (load),
    .shift_o     (shift),
    .res_load_o  (res_load),
    .alu_op_o    (alu_op),
    .ready_o     (READY),
    .init_o      (INIT),
    .compute_o   (COMPUTE),
    .res_o       (RES)
  );

  // Trial subtract: the remainder always stays below B, so a borrow shows up as the MSB.
  always_comb begin
    pr_sh  = (pr_q << 1) | {{WIDTH{1'b0}}, dq_q[WIDTH-1]};
    trial  = pr_sh - {1'b0, b_q};
    borrow = trial[WIDTH];
  end

  // Datapath next-state: operand capture, load, one shift/subtract step, result load.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    dq_d    = dq_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    if (capture) begin
      a_d     = A;
      b_d     = B;
      valid_d = 1'b0;
      dbz_d   = 1'b0;
    end
    if (load) begin
      dq_d  = a_q;
      cnt_d = CW'(WIDTH);
      dz_d  = (b_q == '0);
    end
    if (load || shift) begin
      pr_d = (alu_op == ALU_CLR) ? '0 : (borrow ? pr_sh : trial);
    end
    if (shift) begin
      dq_d  = {dq_q[WIDTH-2:0], ~borrow};
      cnt_d = cnt_q - CW'(1);
    end
    if (res_load) begin
      quo_d   = dz_q ? '1 : dq_q;
      rem_d   = dz_q ? a_q : pr_q[WIDTH-1:0];
      valid_d = 1'b1;
      dbz_d   = dz_q;
    end
  end

  // Datapath registers; reset aborts any operation and clears every visible result.
  always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
    if (!FSM_ARESET_N) begin
      a_q     <= '0;
      b_q     <= '0;
      dq_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      dq_q    <= dq_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign QUOTIENT    = quo_q;
  assign REMAINDER   = rem_q;
  assign VALID       = valid_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Bench for seq_unsigned_divider: a WIDTH=3 and a WIDTH=8 instance, each tracked by an
// operation-level model (captured operands, edges since acceptance, / and % results)
// that is compared against every output on every falling edge.
module tb_seq_unsigned_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] go_v = '0;
  logic [2:0] a3 = '0, b3 = '0, q3, r3;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic [1:0] v_v, dz_v, rdy_v, ini_v, cmp_v, res_v;

  int checks = 0;
  int failures = 0;

  seq_unsigned_divider #(.WIDTH(3)) u_d3 (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go_v[0]), .A(a3), .B(b3),
    .QUOTIENT(q3), .REMAINDER(r3), .VALID(v_v[0]), .DIV_BY_ZERO(dz_v[0]),
    .READY(rdy_v[0]), .INIT(ini_v[0]), .COMPUTE(cmp_v[0]), .RES(res_v[0])
  );

  seq_unsigned_divider #(.WIDTH(8)) u_d8 (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go_v[1]), .A(a8), .B(b8),
    .QUOTIENT(q8), .REMAINDER(r8), .VALID(v_v[1]), .DIV_BY_ZERO(dz_v[1]),
    .READY(rdy_v[1]), .INIT(ini_v[1]), .COMPUTE(cmp_v[1]), .RES(res_v[1])
  );

  function automatic int get_a(int i); return (i == 0) ? int'(a3) : int'(a8); endfunction
  function automatic int get_b(int i); return (i == 0) ? int'(b3) : int'(b8); endfunction
  function automatic int get_q(int i); return (i == 0) ? int'(q3) : int'(q8); endfunction
  function automatic int get_r(int i); return (i == 0) ? int'(r3) : int'(r8); endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int wid[2] = '{3, 8};
  int el[2];      // edges since the accepting edge; 0 means idle
  int tot[2];     // edges from acceptance to result load
  int la[2], lb[2], eq[2], er[2], ev[2], ed[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        el[i] = 0; tot[i] = 0; la[i] = 0; lb[i] = 0;
        eq[i] = 0; er[i] = 0; ev[i] = 0; ed[i] = 0;
      end else if (el[i] == 0) begin
        if (go_v[i]) begin
          la[i] = get_a(i);
          lb[i] = get_b(i);
          ev[i] = 0;
          ed[i] = 0;
          tot[i] = (lb[i] == 0) ? 2 : wid[i] + 2;
          el[i] = 1;
        end
      end else if (el[i] == tot[i]) begin
        eq[i] = (lb[i] == 0) ? (1 << wid[i]) - 1 : la[i] / lb[i];
        er[i] = (lb[i] == 0) ? la[i] : la[i] % lb[i];
        ev[i] = 1;
        ed[i] = (lb[i] == 0) ? 1 : 0;
        el[i] = 0;
      end else begin
        el[i]++;
      end
    end
  end

  // Compare every output of both instances against the model, away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w%0d_quotient", wid[i]),  get_q(i), eq[i]);
      chk($sformatf("w%0d_remainder", wid[i]), get_r(i), er[i]);
      chk($sformatf("w%0d_valid", wid[i]),     int'(v_v[i]), ev[i]);
      chk($sformatf("w%0d_divzero", wid[i]),   int'(dz_v[i]), ed[i]);
      chk($sformatf("w%0d_ready", wid[i]),     int'(rdy_v[i]), int'(el[i] == 0));
      chk($sformatf("w%0d_init", wid[i]),      int'(ini_v[i]), int'(el[i] == 1));
      chk($sformatf("w%0d_res", wid[i]),       int'(res_v[i]), int'(el[i] != 0 && el[i] == tot[i]));
      chk($sformatf("w%0d_compute", wid[i]),   int'(cmp_v[i]), int'(el[i] > 1 && el[i] != tot[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic g, input int a, input int b);
    go_v[i] = g;
    if (i == 0) begin a3 = 3'(a); b3 = 3'(b); end
    else        begin a8 = 8'(a); b8 = 8'(b); end
  endtask

  task automatic wait_ready(input int i);
    for (int k = 0; k < 40 && !rdy_v[i]; k++) tick();
    chk("ready_timeout", int'(rdy_v[i]), 1);
  endtask

  task automatic op(input int i, input int a, input int b);
    drive(i, 1'b1, a, b);
    tick();
    go_v[i] = 1'b0;
    tick();
    wait_ready(i);
  endtask

  initial begin
    int ncmp;
    #12 rst_n = 1'b1;
    tick();
    chk("reset_ready", int'(rdy_v[0]), 1);
    chk("reset_strobes", int'({ini_v[0], cmp_v[0], res_v[0]}), 0);
    chk("reset_valid", int'(v_v[0]), 0);

    // 7/2: results after exactly 5 edges, COMPUTE for 3 cycles
    drive(0, 1'b1, 7, 2);
    tick();
    go_v[0] = 1'b0;
    ncmp = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (cmp_v[0]) ncmp++;
      if (k == 4) chk("t1_valid_early", int'(v_v[0]), 0);
    end
    chk("t1_q", int'(q3), 3);
    chk("t1_r", int'(r3), 1);
    chk("t1_valid", int'(v_v[0]), 1);
    chk("t1_dz", int'(dz_v[0]), 0);
    chk("t1_compute_cycles", ncmp, 3);

    // 5/0: two edges, COMPUTE skipped
    drive(0, 1'b1, 5, 0);
    tick();
    go_v[0] = 1'b0;
    ncmp = 0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      if (cmp_v[0]) ncmp++;
    end
    chk("t2_q", int'(q3), 7);
    chk("t2_r", int'(r3), 5);
    chk("t2_dz", int'(dz_v[0]), 1);
    chk("t2_valid", int'(v_v[0]), 1);
    chk("t2_compute_cycles", ncmp, 0);

    // 3/5 then 7/1 issued in the first IDLE cycle
    drive(0, 1'b1, 3, 5);
    tick();
    go_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t3a_q", int'(q3), 0);
    chk("t3a_r", int'(r3), 3);
    drive(0, 1'b1, 7, 1);
    tick();
    chk("t3b_accepted", int'(ini_v[0]), 1);
    go_v[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t3b_q", int'(q3), 7);
    chk("t3b_r", int'(r3), 0);

    // GO held throughout, operands toggled mid-operation
    drive(0, 1'b1, 6, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      a3 = 3'($urandom);
      b3 = 3'($urandom);
      tick();
    end
    a3 = 3'd2; b3 = 3'd3;
    tick();
    chk("t4_q", int'(q3), 1);
    chk("t4_r", int'(r3), 2);
    chk("t4_ready", int'(rdy_v[0]), 1);
    tick();
    chk("t4_restart", int'(ini_v[0]), 1);
    chk("t4_valid_cleared", int'(v_v[0]), 0);
    go_v[0] = 1'b0;
    tick();
    wait_ready(0);
    tick();
    chk("t4b_q", int'(q3), 0);
    chk("t4b_r", int'(r3), 2);

    // reset in the second COMPUTE cycle
    drive(0, 1'b1, 5, 1);
    tick();
    go_v[0] = 1'b0;
    tick();
    tick();
    chk("t5_in_compute", int'(cmp_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_q", int'(q3), 0);
    chk("t5_r", int'(r3), 0);
    chk("t5_valid", int'(v_v[0]), 0);
    chk("t5_ready", int'(rdy_v[0]), 1);
    chk("t5_compute", int'(cmp_v[0]), 0);
    #3 rst_n = 1'b1;
    tick();
    op(0, 6, 3);
    chk("t5b_q", int'(q3), 2);
    chk("t5b_r", int'(r3), 0);

    // WIDTH=8: 255/16 after exactly 10 edges
    drive(1, 1'b1, 255, 16);
    tick();
    go_v[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) chk("t6_valid_early", int'(v_v[1]), 0);
    end
    chk("t6_q", int'(q8), 15);
    chk("t6_r", int'(r8), 15);
    chk("t6_valid", int'(v_v[1]), 1);

    // every WIDTH=3 operand pair
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        op(0, a, b);

    // random traffic on both widths, including GO while busy
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, ($urandom_range(0, 2) == 0), int'($urandom),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom));
      tick();
    end
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    wait_ready(0);
    wait_ready(1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
